// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single port of the data memory between the CPU load/store
//   path, the PS/2 keyboard writer and the VGA frame reader. Keyboard writes
//   are queued in a small FIFO so the scan-code path never stalls. The grant
//   order is CPU > KB > VGA. Starvation counters can override that order and
//   force a grant to KB or VGA.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   cpu_req/we/addr/wd         CPU access request (held until cpu_gnt)
//   cpu_gnt                    CPU access performed this cycle
//   cpu_rvalid/cpu_rdata       load data, valid the cycle after a load grant
//   kb_valid/addr/data         keyboard write offer (addr is a word index)
//   kb_ready                   FIFO can accept a keyboard write
//   vga_req/vga_addr           VGA read request (held until vga_gnt)
//   vga_gnt                    VGA read performed this cycle
//   vga_rvalid/vga_rdata       read data, valid the cycle after vga_gnt
//   mem_we/addr/wd/rdata       data memory port (asynchronous read)
module dmem_port_arbiter #(
  parameter int KB_DEPTH = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        kb_valid,
  input  logic [31:0] kb_addr,
  input  logic [31:0] kb_data,
  output logic        kb_ready,
  input  logic        vga_req,
  input  logic [31:0] vga_addr,
  output logic        vga_gnt,
  output logic        vga_rvalid,
  output logic [31:0] vga_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rdata
);

  localparam int PTR_W  = $clog2(KB_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(KB_DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

  logic [29:0]       kb_idx_mem  [KB_DEPTH];
  logic [31:0]       kb_data_mem [KB_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  kb_count;
  logic [WAIT_W-1:0] kb_wait, vga_wait;
  logic              kb_empty, kb_full, kb_push, kb_pop, kb_gnt;
  logic              kb_force, vga_force;

  // Word index bits above 29 cannot be expressed as a 32-bit byte address.
  logic unused_kb_addr_hi;
  assign unused_kb_addr_hi = ^kb_addr[31:30];

  assign kb_empty  = (kb_count == '0);
  assign kb_full   = (kb_count == FULL_CNT);
  assign kb_ready  = !kb_full;
  assign kb_push   = kb_valid && kb_ready;
  assign kb_pop    = kb_gnt;
  assign kb_force  = (kb_wait == WAIT_SAT) && !kb_empty;
  assign vga_force = (vga_wait == WAIT_SAT) && vga_req;

  // Grants are suppressed while reset is asserted so that no memory write
  // can be issued in the reset cycle.
  always_comb begin
    cpu_gnt  = 1'b0;
    kb_gnt   = 1'b0;
    vga_gnt  = 1'b0;
    if (!reset) begin
      if (kb_force)        kb_gnt  = 1'b1;
      else if (vga_force)  vga_gnt = 1'b1;
      else if (cpu_req)    cpu_gnt = 1'b1;
      else if (!kb_empty)  kb_gnt  = 1'b1;
      else if (vga_req)    vga_gnt = 1'b1;
    end
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (cpu_gnt) begin
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_wd   = cpu_wd;
    end else if (kb_gnt) begin
      mem_we   = 1'b1;
      mem_addr = {kb_idx_mem[rd_ptr], 2'b00};
      mem_wd   = kb_data_mem[rd_ptr];
    end else if (vga_gnt) begin
      mem_addr = vga_addr;
    end
  end

  // FIFO payload needs no reset; occupancy is tracked by kb_count.
  always_ff @(posedge clk) begin
    if (kb_push) begin
      kb_idx_mem[wr_ptr]  <= kb_addr[29:0];
      kb_data_mem[wr_ptr] <= kb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      kb_count   <= '0;
      kb_wait    <= '0;
      vga_wait   <= '0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      vga_rvalid <= 1'b0;
      vga_rdata  <= '0;
    end else begin
      if (kb_push) wr_ptr <= wr_ptr + 1'b1;
      if (kb_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({kb_push, kb_pop})
        2'b10:   kb_count <= kb_count + 1'b1;
        2'b01:   kb_count <= kb_count - 1'b1;
        default: kb_count <= kb_count;
      endcase

      if (kb_gnt || kb_empty)       kb_wait <= '0;
      else if (kb_wait != WAIT_SAT) kb_wait <= kb_wait + 1'b1;

      if (vga_gnt || !vga_req)       vga_wait <= '0;
      else if (vga_wait != WAIT_SAT) vga_wait <= vga_wait + 1'b1;

      cpu_rvalid <= cpu_gnt && !cpu_we;
      if (cpu_gnt && !cpu_we) cpu_rdata <= mem_rdata;
      vga_rvalid <= vga_gnt;
      if (vga_gnt) vga_rdata <= mem_rdata;
    end
  end

endmodule
